lcd_write_scheduler: RTL
========================

Name: lcd_write_scheduler

Overview:
- Shares one HD44780-style character LCD bus between NUM_REQ requesters. Typical requesters: UART RX echo, digit/timer display fields.
- After reset, runs the LCD power-up/init command sequence itself.
- Then grants requests round-robin. Each grant becomes a set-DDRAM-address command followed by a data write, with enable-pulse and busy-wait timing generated from cycle counters.
- Sits between the display-content logic and the lcd_d/lcd_rs/lcd_rw/lcd_e pins, driven from the divided LCD clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- E_HIGH_CYC, 12, cycles lcd_e is held high per bus cycle.
- CMD_WAIT_CYC, 2000, cycles lcd_e is low after each normal command or data write.
- CLEAR_WAIT_CYC, 80000, cycles lcd_e is low after the clear-display command (0x01).
- PWRUP_WAIT_CYC, 1000000, cycles idle after reset before the first init command.

Ports:
- clock, input, 1, LCD-domain clock; the only clock.
- reset, input, 1, synchronous, active-high.
- req, input, NUM_REQ, per-requester write request (level).
- req_addr, input, 7*NUM_REQ, DDRAM address; requester i uses bits [7i+6:7i].
- req_data, input, 8*NUM_REQ, character code; requester i uses bits [8i+7:8i].
- grant, output, NUM_REQ, one-hot, one-cycle pulse when a request is accepted.
- ready, output, 1, init sequence complete.
- busy, output, 1, bus cycle in progress or init not done.
- lcd_d, output, 8, LCD data bus.
- lcd_rs, output, 1, 0 = command, 1 = data.
- lcd_rw, output, 1, tied 0 (write only).
- lcd_e, output, 1, LCD enable strobe.

Behaviour:
- Reset (synchronous, any state) sets the following on the next edge; a reset mid-cycle aborts the cycle and reruns the full init:
  - lcd_d=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0
  - grant=0, ready=0, busy=1
  - round-robin pointer = 0
  - state=PWRUP
- States: PWRUP, INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, ADDR_SETUP, ADDR_PULSE, ADDR_HOLD, DATA_SETUP, DATA_PULSE, DATA_HOLD.
- PWRUP: count PWRUP_WAIT_CYC cycles, then go to INIT_SETUP with init index 0.
- Init commands, in order, all with rs=0: 0x38, 0x0C, 0x06, 0x01.
  - SETUP: 1 cycle, lcd_d/lcd_rs driven, lcd_e=0.
  - PULSE: E_HIGH_CYC cycles, lcd_e=1, lcd_d/lcd_rs stable.
  - HOLD: lcd_e=0 for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC after 0x01.
  - After the 4th HOLD: ready=1, busy=0, go to IDLE.
- IDLE arbitration:
  - If any req bit is set, select the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - grant[i]=1 for exactly that cycle. Latch req_addr[i] and req_data[i]. Pointer becomes (i+1) mod NUM_REQ. busy=1 from the next cycle.
  - Simultaneous requests are served one per transaction in round-robin order. No requester is granted twice while another holds req continuously.
- Requester contract: hold req/addr/data stable until grant, then drop req the cycle after grant. A req still high at the next IDLE is a new request.
- Address cycle: ADDR_* runs the same SETUP/PULSE/HOLD timing with lcd_rs=0, lcd_d = {1'b1, latched_addr}, HOLD = CMD_WAIT_CYC.
- Data cycle: DATA_* runs the same timing with lcd_rs=1, lcd_d = latched_data. After DATA_HOLD: busy=0, return to IDLE.
- Latency: grant in cycle T → ADDR_SETUP at T+1 → lcd_e rises at T+2.
- Transaction length from grant to next possible grant: 1 + 2*(1 + E_HIGH_CYC + CMD_WAIT_CYC) cycles.
- req is ignored (no grant) in every state except IDLE with ready=1.
- Counters are wide enough for PWRUP_WAIT_CYC. Each counter reloads on entry to its state and never wraps.

Optional Feature:
- Macro: LCD_ADDR_SKIP_EN.
- When defined, the block tracks the LCD cursor:
  - After each data write, cursor = addr+1, with 0x27→0x40 and 0x67→0x00.
  - cursor_valid is cleared by reset/init and set after the first data write.
  - If cursor_valid and latched addr == cursor, the scheduler skips ADDR_* and goes straight from grant to DATA_SETUP; lcd_e then rises at T+2 of the data cycle.
- When undefined, every transaction issues the address command.

Test Plan:
(Sim params: E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=10, PWRUP_WAIT_CYC=20, NUM_REQ=4.)
- Reset release → 20 idle cycles; then lcd_e pulses 2 cycles each with lcd_d=0x38,0x0C,0x06,0x01, rs=0; ready rises after the 10-cycle clear wait; no grant while ready=0 even with req=4'b1111.
- req[2] alone, addr=0x05, data=0x41 → grant=4'b0100 one cycle; lcd_d=0x85 rs=0 pulse, then lcd_d=0x41 rs=1 pulse; busy low 15 cycles after grant.
- req=4'b1011 held, pointer=0 → grants in order 0,1,3,0,1,3; never two consecutive grants to the same requester.
- Reset asserted during DATA_PULSE → next cycle lcd_e=0, ready=0, grant=0; full 4-command init repeats.
- With LCD_ADDR_SKIP_EN: write addr 0x27 then addr 0x40 → second transaction has no 0x80-class command, only the data pulse. Write addr 0x10 then 0x10 → both issue address commands (0x90).
- Without LCD_ADDR_SKIP_EN: writes to 0x00 then 0x01 → two address commands, 0x80 and 0x81.

Source files
------------

// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - shares one HD44780 write-only bus between NUM_REQ requesters, with power-up init
// Optional LCD_ADDR_SKIP_EN: omit the set-address command when the LCD cursor already sits on the target address.
module lcd_write_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int E_HIGH_CYC     = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000,
  parameter int PWRUP_WAIT_CYC = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   ready,
  output logic                   busy,
  output logic [7:0]             lcd_d,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_e
);
  localparam int MAX_A   = (PWRUP_WAIT_CYC > CLEAR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    PWRUP, INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE,
    ADDR_SETUP, ADDR_PULSE, ADDR_HOLD, DATA_SETUP, DATA_PULSE, DATA_HOLD
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, limit;
  logic [1:0]    init_idx, init_idx_next;
  logic [PW-1:0] ptr, ptr_next, sel;
  logic [6:0]    addr_q, addr_next;
  logic [7:0]    data_q, data_next, init_cmd;
  logic          found, done;
  int            scan;
  logic [6:0]    addr_arr [NUM_REQ];
  logic [7:0]    data_arr [NUM_REQ];
`ifdef LCD_ADDR_SKIP_EN
  logic [6:0]    cursor, cursor_next;
  logic          cursor_valid, cursor_valid_next;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign addr_arr[g] = req_addr[7*g +: 7];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PWRUP;
      cnt      <= '0;
      init_idx <= '0;
      ptr      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef LCD_ADDR_SKIP_EN
      cursor       <= '0;
      cursor_valid <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      init_idx <= init_idx_next;
      ptr      <= ptr_next;
      addr_q   <= addr_next;
      data_q   <= data_next;
`ifdef LCD_ADDR_SKIP_EN
      cursor       <= cursor_next;
      cursor_valid <= cursor_valid_next;
`endif
    end
  end

  always_comb begin
    case (init_idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  end

  // Terminal count of the current state; cnt restarts at 0 on every state entry.
  always_comb begin
    limit = '0;
    case (state)
      PWRUP:                              limit = CW'(PWRUP_WAIT_CYC - 1);
      INIT_PULSE, ADDR_PULSE, DATA_PULSE: limit = CW'(E_HIGH_CYC - 1);
      INIT_HOLD: limit = (init_idx == 2'd3) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
      ADDR_HOLD, DATA_HOLD:               limit = CW'(CMD_WAIT_CYC - 1);
      default:                            limit = '0;
    endcase
  end

  assign done = (cnt == limit);

  // First asserted request at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[PW'(scan)]) begin
        found = 1'b1;
        sel   = PW'(scan);
      end
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt + 1'b1;
    init_idx_next = init_idx;
    ptr_next      = ptr;
    addr_next     = addr_q;
    data_next     = data_q;
`ifdef LCD_ADDR_SKIP_EN
    cursor_next       = cursor;
    cursor_valid_next = cursor_valid;
`endif
    grant  = '0;
    ready  = 1'b1;
    busy   = 1'b1;
    lcd_d  = 8'h00;
    lcd_rs = 1'b0;
    lcd_rw = 1'b0;
    lcd_e  = 1'b0;
    case (state)
      PWRUP: begin
        ready = 1'b0;
`ifdef LCD_ADDR_SKIP_EN
        cursor_valid_next = 1'b0;
`endif
        if (done) begin
          state_next    = INIT_SETUP;
          init_idx_next = 2'd0;
        end
      end
      INIT_SETUP: begin
        ready      = 1'b0;
        lcd_d      = init_cmd;
        state_next = INIT_PULSE;
      end
      INIT_PULSE: begin
        ready = 1'b0;
        lcd_d = init_cmd;
        lcd_e = 1'b1;
        if (done) state_next = INIT_HOLD;
      end
      INIT_HOLD: begin
        ready = 1'b0;
        lcd_d = init_cmd;
        if (done) begin
          if (init_idx == 2'd3) begin
            state_next = IDLE;
          end else begin
            init_idx_next = init_idx + 2'd1;
            state_next    = INIT_SETUP;
          end
        end
      end
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          grant[sel] = 1'b1;
          addr_next  = addr_arr[sel];
          data_next  = data_arr[sel];
          ptr_next   = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          state_next = ADDR_SETUP;
`ifdef LCD_ADDR_SKIP_EN
          if (cursor_valid && addr_arr[sel] == cursor) state_next = DATA_SETUP;
`endif
        end
      end
      ADDR_SETUP: begin
        lcd_d      = {1'b1, addr_q};
        state_next = ADDR_PULSE;
      end
      ADDR_PULSE: begin
        lcd_d = {1'b1, addr_q};
        lcd_e = 1'b1;
        if (done) state_next = ADDR_HOLD;
      end
      ADDR_HOLD: begin
        lcd_d = {1'b1, addr_q};
        if (done) state_next = DATA_SETUP;
      end
      DATA_SETUP: begin
        lcd_rs     = 1'b1;
        lcd_d      = data_q;
        state_next = DATA_PULSE;
      end
      DATA_PULSE: begin
        lcd_rs = 1'b1;
        lcd_d  = data_q;
        lcd_e  = 1'b1;
        if (done) state_next = DATA_HOLD;
      end
      DATA_HOLD: begin
        lcd_rs = 1'b1;
        lcd_d  = data_q;
        if (done) begin
          state_next = IDLE;
`ifdef LCD_ADDR_SKIP_EN
          // The LCD auto-increments; the two line ends jump to the other line.
          cursor_next = (addr_q == 7'h27) ? 7'h40 :
                        (addr_q == 7'h67) ? 7'h00 : addr_q + 7'd1;
          cursor_valid_next = 1'b1;
`endif
        end
      end
      default: state_next = PWRUP;
    endcase
    if (state_next != state || state_next == IDLE) cnt_next = '0;
  end
endmodule
